// File: rtl/hams_sorted_drain_if.sv
// Sorted-stream drain bundle: controller beat input, host valid/ready output and job status.
// The slave modport is the drain block; the master modport is the controller/host side.
interface hams_sorted_drain_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 11
);
  logic                   start;
  logic [DATA_WIDTH-1:0]  sorted_data;
  logic                   sorted_data_vld;
  logic                   merge_sort_complete;
  logic                   pause;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_vld;
  logic                   out_rdy;
  logic [COUNT_WIDTH-1:0] elem_count;
  logic                   order_err;
  logic                   overflow;
  logic                   drain_done;

  modport slave (
    input  start, sorted_data, sorted_data_vld, merge_sort_complete, out_rdy,
    output pause, out_data, out_vld, elem_count, order_err, overflow, drain_done
  );

  modport master (
    output start, sorted_data, sorted_data_vld, merge_sort_complete, out_rdy,
    input  pause, out_data, out_vld, elem_count, order_err, overflow, drain_done
  );
endinterface

// File: rtl/hams_sorted_drain.sv
// Drain FIFO for the merge-sort output stream: buffers beats, back-pressures the controller,
// re-issues data on valid/ready, counts beats, checks ascending order and flags job completion.
module hams_sorted_drain #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SKID        = 4,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input logic             i_clk,
  input logic             i_rst_n,
  hams_sorted_drain_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e                 r_state;
  logic [PtrW-1:0]        r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_prev;
  logic                   r_has_prev;
  logic [COUNT_WIDTH-1:0] r_elem_count;
  logic                   r_order_err, r_overflow, r_pause, r_drain_done;

  logic                   w_empty, w_full, w_active, w_push, w_pop, w_wr, w_drop;
  logic                   w_flush_exit, w_active_next, w_pause_next;
  logic [PtrW-1:0]        w_wptr_next, w_rptr_next, w_occ_next;

  always_comb begin
    w_empty      = (r_wptr == r_rptr);
    w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_active     = (r_state == StCollect) || (r_state == StFlush);
    w_push       = w_active && bus.sorted_data_vld;
    w_pop        = !w_empty && bus.out_rdy;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    w_wr         = w_push && (!w_full || w_pop);
    w_drop       = w_push && w_full && !w_pop;
    w_wptr_next  = r_wptr + {{AW{1'b0}}, w_wr};
    w_rptr_next  = r_rptr + {{AW{1'b0}}, w_pop};
    w_occ_next   = w_wptr_next - w_rptr_next;
    w_flush_exit = w_empty && !w_push;
    w_active_next = (r_state == StCollect) || ((r_state == StFlush) && !w_flush_exit);
    w_pause_next = !bus.start && w_active_next &&
                   ((PtrW'(DEPTH) - w_occ_next) <= PtrW'(SKID));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_prev       <= '0;
      r_has_prev   <= 1'b0;
      r_elem_count <= '0;
      r_order_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_pause      <= 1'b0;
      r_drain_done <= 1'b0;
    end else if (bus.start) begin
      r_state      <= StCollect;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_prev       <= '0;
      r_has_prev   <= 1'b0;
      r_elem_count <= '0;
      r_order_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_pause      <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_wptr       <= w_wptr_next;
      r_rptr       <= w_rptr_next;
      r_pause      <= w_pause_next;
      r_drain_done <= 1'b0;
      unique case (r_state)
        StIdle:    r_state <= StIdle;
        StCollect: if (bus.merge_sort_complete) r_state <= StFlush;
        StFlush: begin
          if (w_flush_exit) begin
            r_state      <= StDone;
            r_drain_done <= 1'b1;
          end
        end
        StDone:    r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase
      if (w_push) begin
        if (r_has_prev && (bus.sorted_data < r_prev)) r_order_err <= 1'b1;
        r_prev     <= bus.sorted_data;
        r_has_prev <= 1'b1;
        if (r_elem_count != '1) r_elem_count <= r_elem_count + COUNT_WIDTH'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; visibility is governed entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= bus.sorted_data;
  end

  assign bus.out_vld    = !w_empty;
  assign bus.out_data   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign bus.pause      = r_pause;
  assign bus.elem_count = r_elem_count;
  assign bus.order_err  = r_order_err;
  assign bus.overflow   = r_overflow;
  assign bus.drain_done = r_drain_done;

endmodule

// File: tb/tb_hams_sorted_drain.sv
// Self-checking bench for hams_sorted_drain: directed scenarios plus randomized jobs,
// compared every cycle against a queue-based job model.
module tb_hams_sorted_drain;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SKID  = 4;
  localparam int unsigned CW    = 11;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hams_sorted_drain_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  hams_sorted_drain #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SKID       (SKID),
    .COUNT_WIDTH(CW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Job model: 0 idle, 1 collecting, 2 flushing, 3 done
  int            m_phase;
  logic [DW-1:0] m_q[$];
  int            m_count;
  bit            m_oerr, m_ovf, m_have_prev, m_pause, m_done;
  logic [DW-1:0] m_prev;
  int            done_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_count = 0; m_oerr = 0; m_ovf = 0;
    m_have_prev = 0; m_prev = '0; m_pause = 0; m_done = 0;
  endtask

  task automatic model_update(input bit st, input bit v, input logic [DW-1:0] d,
                              input bit c, input bit r);
    bit pop, push, was_empty;
    int nxt;
    if (st) begin
      model_reset();
      m_phase = 1;
      return;
    end
    was_empty = (m_q.size() == 0);
    pop  = !was_empty && r;
    push = (m_phase == 1 || m_phase == 2) && v;
    if (push) begin
      if (m_have_prev && d < m_prev) m_oerr = 1;
      m_prev = d;
      m_have_prev = 1;
      if (m_count < CMAX) m_count++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1;
    end
    case (m_phase)
      1:       nxt = c ? 2 : 1;
      2:       nxt = (was_empty && !push) ? 3 : 2;
      default: nxt = 0;
    endcase
    m_phase = nxt;
    m_done  = (nxt == 3);
    m_pause = (nxt == 1 || nxt == 2) && ((DEPTH - m_q.size()) <= SKID);
  endtask

  task automatic check_all();
    logic [DW-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    chk("out_vld",    bus.out_vld,    m_q.size() > 0);
    chk("out_data",   bus.out_data,   head);
    chk("pause",      bus.pause,      m_pause);
    chk("drain_done", bus.drain_done, m_done);
    chk("elem_count", bus.elem_count, m_count);
    chk("order_err",  bus.order_err,  m_oerr);
    chk("overflow",   bus.overflow,   m_ovf);
  endtask

  task automatic step(input bit st, input bit v, input logic [DW-1:0] d,
                      input bit c, input bit r);
    bus.start = st; bus.sorted_data_vld = v; bus.sorted_data = d;
    bus.merge_sort_complete = c; bus.out_rdy = r;
    @(posedge clk);
    model_update(st, v, d, c, r);
    #1;
    if (bus.drain_done === 1'b1) done_seen++;
    check_all();
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, '0, 0, 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    bus.start = 0; bus.sorted_data_vld = 0; bus.sorted_data = '0;
    bus.merge_sort_complete = 0; bus.out_rdy = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // 1: eight ascending beats with host always ready
    done_seen = 0;
    step(1, 0, '0, 0, 1);
    for (int i = 1; i <= 8; i++) step(0, 1, DW'(i), 0, 1);
    step(0, 0, '0, 1, 1);
    drain(5);
    chk("t1_done_pulses", done_seen, 1);

    // 2: host stalled, pause rises at occupancy 12 and falls on release
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 12; i++) step(0, 1, DW'(i * 3), 0, 0);
    chk("t2_pause_high", bus.pause, 1'b1);
    step(0, 0, '0, 1, 1);
    drain(16);

    // 3: out-of-order beat sets sticky order_err
    step(1, 0, '0, 0, 1);
    step(0, 1, 16'd5, 0, 1);
    step(0, 1, 16'd7, 0, 1);
    step(0, 1, 16'd3, 0, 1);
    step(0, 1, 16'd9, 0, 1);
    step(0, 0, '0, 1, 1);
    drain(4);
    chk("t3_order_sticky", bus.order_err, 1'b1);

    // 4: 17 beats into a stalled FIFO
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 17; i++) step(0, 1, DW'(i), 0, 0);
    chk("t4_overflow", bus.overflow, 1'b1);
    step(0, 0, '0, 1, 1);
    drain(20);

    // 5: full FIFO with concurrent push and pop
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 16; i++) step(0, 1, DW'(i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, DW'(100 + i), 0, 1);
    chk("t5_no_overflow", bus.overflow, 1'b0);
    step(0, 0, '0, 1, 1);
    drain(20);

    // 6: asynchronous reset with beats buffered, then a fresh job
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, DW'(10 + i), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, '0, 0, 1);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(i), 0, 1);
    step(0, 0, '0, 1, 1);
    drain(6);

    // Randomized jobs: mostly ascending data, random valid/ready, occasional disorder
    for (int job = 0; job < 4; job++) begin
      d = DW'($urandom_range(0, 50));
      step(1, 0, '0, 0, $urandom_range(0, 1));
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 19) == 0) d = DW'($urandom);
        else d = d + DW'($urandom_range(0, 3));
        step(0, $urandom_range(0, 9) < 7, d, 0, $urandom_range(0, 3) != 0);
      end
      step(0, 0, '0, 1, 1);
      drain(24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
